// File: rtl/conv2d_ch_stream.sv
// rtl/conv2d_ch_stream.sv - multi-channel 3x3 convolution engine with frame buffer and streaming I/O
module conv2d_ch_stream #(
    parameter int CH    = 3,
    parameter int IMG_W = 6,
    parameter int IMG_H = 6,
    parameter int DW    = 8,
    parameter int WW    = 4,
    parameter int OW    = 20,
    localparam int CHW  = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               mode,
    output logic               busy,
    output logic               done,
    input  logic               wload_en,
    input  logic [CHW-1:0]     wload_ch,
    input  logic [3:0]         wload_idx,
    input  logic [WW-1:0]      wload_data,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [CH*DW-1:0]   in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CH*OW-1:0]   out_data
);

    localparam int NPIX = IMG_W * IMG_H;
    localparam int AW   = $clog2(NPIX);
    localparam int RW   = $clog2(IMG_H);
    localparam int CW   = $clog2(IMG_W);
    localparam int PW   = DW + WW;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CALC} state_t;

    state_t state, state_nxt;

    logic                 mode_q;
    logic [RW-1:0]        ld_r, pos_r, nxt_r, sel_r;
    logic [CW-1:0]        ld_c, pos_c, nxt_c, sel_c;
    logic signed [WW-1:0] wt [CH][9];
    logic [DW-1:0]        fbuf [CH][NPIX];

    logic                 in_fire, ld_last, out_fire, pos_last, wload_ok;
    logic [AW-1:0]        wr_addr, rd_addr;
    logic [DW-1:0]        xs;
    logic signed [WW-1:0] ws;
    logic signed [PW-1:0] prod;
    logic signed [OW-1:0] res [CH];
    logic signed [OW-1:0] sum_all;
    logic [CH*OW-1:0]     conv_data;

    assign busy     = (state != S_IDLE);
    assign in_ready = (state == S_LOAD);
    assign in_fire  = in_valid && in_ready;
    assign ld_last  = (ld_r == RW'(IMG_H - 1)) && (ld_c == CW'(IMG_W - 1));
    assign out_fire = (state == S_CALC) && out_valid && out_ready;
    assign pos_last = (pos_r == RW'(IMG_H - 3)) && (pos_c == CW'(IMG_W - 3));
    assign wload_ok = (int'(wload_ch) < CH) && (wload_idx <= 4'd8);
    assign wr_addr  = AW'(int'(ld_r) * IMG_W + int'(ld_c));

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state: start opens a frame, last input beat enters CALC, last output handshake returns to IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_LOAD;
            S_LOAD:  if (in_fire && ld_last) state_nxt = S_CALC;
            S_CALC:  if (out_fire && pos_last) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Window selection: the position that the output register loads next (current one before the first output)
    always_comb begin
        nxt_r = pos_r;
        nxt_c = pos_c + CW'(1);
        if (pos_last) begin
            nxt_r = '0;
            nxt_c = '0;
        end else if (pos_c == CW'(IMG_W - 3)) begin
            nxt_r = pos_r + RW'(1);
            nxt_c = '0;
        end
        sel_r = out_valid ? nxt_r : pos_r;
        sel_c = out_valid ? nxt_c : pos_c;
    end

    // Per-channel 3x3 flipped-kernel convolution of the selected window, then lane packing by mode
    always_comb begin
        conv_data = '0;
        sum_all   = '0;
        rd_addr   = '0;
        xs        = '0;
        ws        = '0;
        prod      = '0;
        for (int c = 0; c < CH; c++) begin
            res[c] = '0;
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    rd_addr = AW'((int'(sel_r) + i) * IMG_W + int'(sel_c) + j);
                    xs      = fbuf[c][rd_addr];
                    ws      = wt[c][8 - (3 * i + j)];
                    prod    = $signed({{WW{xs[DW-1]}}, xs}) * $signed({{DW{ws[WW-1]}}, ws});
                    res[c]  = res[c] + $signed({{(OW - PW){prod[PW-1]}}, prod});
                end
            end
            sum_all = sum_all + res[c];
            if (!mode_q) conv_data[c*OW +: OW] = res[c];
        end
        if (mode_q) conv_data[0 +: OW] = sum_all;
    end

    // Frame buffer capture; contents persist across frames
    always_ff @(posedge clk) begin
        if (in_fire) begin
            for (int c = 0; c < CH; c++) fbuf[c][wr_addr] <= in_data[c*DW +: DW];
        end
    end

    // Weights, counters and the output register with its done pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < CH; c++) begin
                for (int t = 0; t < 9; t++) wt[c][t] <= '0;
            end
            mode_q    <= 1'b0;
            ld_r      <= '0;
            ld_c      <= '0;
            pos_r     <= '0;
            pos_c     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == S_IDLE) begin
                if (wload_en && wload_ok) wt[wload_ch][wload_idx] <= wload_data;
                if (start) begin
                    mode_q <= mode;
                    ld_r   <= '0;
                    ld_c   <= '0;
                    pos_r  <= '0;
                    pos_c  <= '0;
                end
            end
            if (in_fire) begin
                if (ld_c == CW'(IMG_W - 1)) begin
                    ld_c <= '0;
                    ld_r <= ld_last ? '0 : ld_r + RW'(1);
                end else begin
                    ld_c <= ld_c + CW'(1);
                end
            end
            if (state == S_CALC) begin
                if (!out_valid) begin
                    out_valid <= 1'b1;
                    out_data  <= conv_data;
                end else if (out_ready) begin
                    pos_r <= nxt_r;
                    pos_c <= nxt_c;
                    if (pos_last) begin
                        out_valid <= 1'b0;
                        out_data  <= '0;
                        done      <= 1'b1;
                    end else begin
                        out_data  <= conv_data;
                    end
                end
            end
        end
    end

endmodule
